// File: rtl/apb_slave_regfile_pkg.sv
// Shared widths, ID default and FSM state encoding for the APB register-file completer.
package apb_slave_regfile_pkg;

   localparam int ADDR_WIDTH = 8;
   localparam int DATA_WIDTH = 32;

   localparam logic [DATA_WIDTH-1:0] APB_SLV_ID_VALUE = 32'hA9B0_0001;

   typedef enum logic [1:0] {
      SLV_IDLE = 2'd0,
      SLV_WAIT = 2'd1,
      SLV_ACK  = 2'd2
   } apb_slv_state_e;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB3 bus bundle between master and the register-file completer.
interface apb_slave_regfile_if;

   logic                                             PSEL;
   logic                                             PENABLE;
   logic                                             PWRITE;
   logic [apb_slave_regfile_pkg::ADDR_WIDTH-1:0]     PADDR;
   logic [apb_slave_regfile_pkg::DATA_WIDTH-1:0]     PWDATA;
   logic [apb_slave_regfile_pkg::DATA_WIDTH-1:0]     PRDATA;
   logic                                             PREADY;
   logic                                             PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_slave_wait_ctr.sv
// Wait-state down-counter: load on setup, decrement while waiting, done at terminal count zero.
module apb_slave_wait_ctr #(
   parameter int W = 4
) (
   input  logic         clk_sys,
   input  logic         rst_b,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer with read-only ID at reg 0 and read/write regs 1..NUM_REGS-1.
// Define APB_SLV_WAIT_EN to insert WAIT_CYCLES wait states per access.
//
// state | meaning
// IDLE  | no transfer; waiting for a setup phase (PSEL=1, PENABLE=0)
// WAIT  | access phase, PREADY low while the wait counter runs down
// ACK   | PREADY high for one cycle; write commits on the closing edge
module apb_slave_regfile
   import apb_slave_regfile_pkg::*;
#(
   parameter int                    NUM_REGS    = 16,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE    = APB_SLV_ID_VALUE,
   parameter int                    WAIT_CYCLES = 2
) (
   input  logic                PCLK,
   input  logic                PRESETn,
   apb_slave_regfile_if.slave  apb
);

   localparam int IDX_W = ADDR_WIDTH - 2;

   localparam logic [1:0] ST_IDLE = SLV_IDLE;
   localparam logic [1:0] ST_ACK  = SLV_ACK;
`ifdef APB_SLV_WAIT_EN
   localparam logic [1:0] ST_WAIT = SLV_WAIT;
`endif

   if (NUM_REGS < 2 || NUM_REGS > 2**IDX_W || WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_param_chk
      $error("apb_slave_regfile: parameter out of range");
   end

   logic [1:0]            state_q, state_d;
   logic [IDX_W-1:0]      idx_q;
   logic                  wr_q, err_q;
   logic                  pready_q, pslverr_q;
   logic [DATA_WIDTH-1:0] prdata_q;
   logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

   logic                  setup, to_ack;
   logic [IDX_W-1:0]      idx_in, rd_idx;
   logic                  cur_wr, cur_err;
   logic [DATA_WIDTH-1:0] rd_val, resp_data;

   function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] addr, input logic wr);
      logic [IDX_W-1:0] idx;
      idx = addr[ADDR_WIDTH-1:2];
      return (addr[1:0] != 2'b00) || (int'(idx) >= NUM_REGS) || (wr && (idx == '0));
   endfunction

   assign setup  = apb.PSEL & ~apb.PENABLE;
   assign idx_in = apb.PADDR[ADDR_WIDTH-1:2];

   // Zero-wait responses are built straight from the setup-phase bus; waited ones from the latched copy.
   assign rd_idx  = (state_q == ST_IDLE) ? idx_in : idx_q;
   assign cur_wr  = (state_q == ST_IDLE) ? apb.PWRITE : wr_q;
   assign cur_err = (state_q == ST_IDLE) ? addr_err(apb.PADDR, apb.PWRITE) : err_q;

   always_comb begin
      rd_val = '0;
      if (rd_idx == '0) rd_val = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (rd_idx == IDX_W'(i)) rd_val = regs[i];
      end
   end

   assign resp_data = (cur_wr || cur_err) ? '0 : rd_val;

`ifdef APB_SLV_WAIT_EN
   logic ctr_done;

   apb_slave_wait_ctr #(.W(4)) u_wait_ctr (
      .clk_sys  (PCLK),
      .rst_b    (PRESETn),
      .load     ((state_q == ST_IDLE) && setup),
      .dec      (state_q == ST_WAIT),
      .load_val (4'(WAIT_CYCLES - 1)),
      .done     (ctr_done)
   );
`endif

   always_comb begin
      state_d = state_q;
      to_ack  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (setup) begin
`ifdef APB_SLV_WAIT_EN
               if (WAIT_CYCLES == 0) begin
                  to_ack  = 1'b1;
                  state_d = ST_ACK;
               end else begin
                  state_d = ST_WAIT;
               end
`else
               to_ack  = 1'b1;
               state_d = ST_ACK;
`endif
            end
         end
`ifdef APB_SLV_WAIT_EN
         ST_WAIT: begin
            if (!apb.PSEL) begin
               state_d = ST_IDLE;
            end else if (ctr_done) begin
               to_ack  = 1'b1;
               state_d = ST_ACK;
            end
         end
`endif
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         wr_q      <= 1'b0;
         err_q     <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         pready_q  <= to_ack;
         pslverr_q <= to_ack & cur_err;
         prdata_q  <= to_ack ? resp_data : '0;
         if ((state_q == ST_IDLE) && setup) begin
            idx_q <= idx_in;
            wr_q  <= apb.PWRITE;
            err_q <= addr_err(apb.PADDR, apb.PWRITE);
         end
      end
   end

   // Write lands only if the master is still in a valid write access on the ACK edge.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
      end else if ((state_q == ST_ACK) && apb.PSEL && apb.PENABLE && apb.PWRITE && !err_q) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (idx_q == IDX_W'(i)) regs[i] <= apb.PWDATA;
         end
      end
   end

   assign apb.PREADY  = pready_q;
   assign apb.PSLVERR = pslverr_q;
   assign apb.PRDATA  = prdata_q;

endmodule
